// File: rtl/cb_vram_fetcher.sv
// Codebook fetcher: streams the 256x64-bit VQ codebook from VRAM into the codebook cache
// using fixed-length read bursts, one vram_valid pulse per word, in ascending order.
// Optional build macro CB_FETCH_TIMEOUT_EN: a stalled fetch is completed with zero words
// after TIMEOUT idle cycles and flagged on timeout_err.
module cb_vram_fetcher #(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cache_wait,
  input  logic [7:0]        ram_read_offset,
  input  logic [ADDR_W-1:0] cb_base_addr,
  input  logic              fetch_abort,
  output logic              vram_valid,
  output logic [63:0]       cache_din,
  output logic              ddr_rd,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [7:0]        ddr_burstcnt,
  input  logic              ddr_busy,
  input  logic [63:0]       ddr_dout,
  input  logic              ddr_dout_ready,
  output logic              sync_err,
  output logic              timeout_err
);

  // Reject illegal burst lengths and a zero timeout at elaboration.
  if (BURST_LEN == 0 || BURST_LEN > 256 || (BURST_LEN & (BURST_LEN - 1)) != 0 ||
      TIMEOUT == 0) begin : g_bad_param
    $error("cb_vram_fetcher: illegal BURST_LEN or TIMEOUT");
  end

  localparam logic [7:0] LastBeat = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    StIdle, StReq, StData, StDrain, StDone
`ifdef CB_FETCH_TIMEOUT_EN
    , StFill
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [8:0]        word_cnt_q, word_cnt_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              valid_q, valid_d;
  logic [63:0]       din_q, din_d;
  logic [7:0]        emit_idx_q, emit_idx_d;
  logic              sync_err_q, sync_err_d;

`ifdef CB_FETCH_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  // Next-state, datapath and error-flag logic.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    beat_cnt_d = beat_cnt_q;
    base_d     = base_q;
    valid_d    = 1'b0;
    din_d      = din_q;
    emit_idx_d = emit_idx_q;
    // The cache must be expecting exactly the word currently on cache_din.
    sync_err_d = sync_err_q | (valid_q & (ram_read_offset != emit_idx_q));
`ifdef CB_FETCH_TIMEOUT_EN
    tmo_d         = '0;
    timeout_err_d = timeout_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cache_wait) begin
          base_d     = cb_base_addr;
          word_cnt_d = '0;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (!ddr_busy) begin
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        if (ddr_dout_ready) begin
          valid_d    = 1'b1;
          din_d      = ddr_dout;
          emit_idx_d = word_cnt_q[7:0];
          word_cnt_d = word_cnt_q + 9'd1;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == LastBeat) begin
            state_d = (word_cnt_q == 9'd255) ? StDone : StReq;
          end
        end
      end
      StDrain: begin
        if (ddr_dout_ready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == LastBeat) state_d = StIdle;
        end
      end
      StDone: begin
        if (!cache_wait) state_d = StIdle;
      end
`ifdef CB_FETCH_TIMEOUT_EN
      StFill: begin
        valid_d    = 1'b1;
        din_d      = '0;
        emit_idx_d = word_cnt_q[7:0];
        word_cnt_d = word_cnt_q + 9'd1;
        if (word_cnt_q == 9'd255) state_d = StDone;
      end
`endif
      default: state_d = StIdle;
    endcase

`ifdef CB_FETCH_TIMEOUT_EN
    // Idle cycles counted only while waiting on VRAM; any acceptance or beat clears.
    if ((state_q == StReq && ddr_busy) || (state_q == StData && !ddr_dout_ready)) begin
      if (tmo_q == TmoW'(TIMEOUT - 1)) begin
        state_d       = StFill;
        timeout_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    // Abort wins over everything; an accepted burst must still be drained.
    if (fetch_abort) begin
      valid_d = 1'b0;
      if (state_q != StDrain) begin
        state_d = StIdle;
        if (state_q == StData && !(ddr_dout_ready && beat_cnt_q == LastBeat)) begin
          state_d = StDrain;
        end
        if (state_q == StReq && !ddr_busy) begin
          beat_cnt_d = '0;
          state_d    = StDrain;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      beat_cnt_q <= '0;
      base_q     <= '0;
      valid_q    <= 1'b0;
      din_q      <= '0;
      emit_idx_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      base_q     <= base_d;
      valid_q    <= valid_d;
      din_q      <= din_d;
      emit_idx_q <= emit_idx_d;
      sync_err_q <= sync_err_d;
    end
  end

`ifdef CB_FETCH_TIMEOUT_EN
  // Timeout counter and sticky timeout flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign vram_valid   = valid_q;
  assign cache_din    = din_q;
  assign ddr_rd       = (state_q == StReq);
  assign ddr_addr     = base_q + ADDR_W'(word_cnt_q);
  // A 256-word burst encodes as 0 in the 8-bit count.
  assign ddr_burstcnt = 8'(BURST_LEN);
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_cb_vram_fetcher.sv
// Scoreboard bench for cb_vram_fetcher: stimulus pushes expected words and request addresses,
// a negedge monitor pops and compares on every vram_valid and every accepted request.
module tb_cb_vram_fetcher;

  logic        clock;
  logic        reset_n;
  logic        cache_wait;
  logic [7:0]  ram_read_offset;
  logic [19:0] cb_base_addr;
  logic        fetch_abort;
  logic        vram_valid;
  logic [63:0] cache_din;
  logic        ddr_rd;
  logic [19:0] ddr_addr;
  logic [7:0]  ddr_burstcnt;
  logic        ddr_busy;
  logic [63:0] ddr_dout;
  logic        ddr_dout_ready;
  logic        sync_err;
  logic        timeout_err;

  cb_vram_fetcher #(
    .BURST_LEN(8),
    .ADDR_W   (20),
    .TIMEOUT  (16)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cache_wait     (cache_wait),
    .ram_read_offset(ram_read_offset),
    .cb_base_addr   (cb_base_addr),
    .fetch_abort    (fetch_abort),
    .vram_valid     (vram_valid),
    .cache_din      (cache_din),
    .ddr_rd         (ddr_rd),
    .ddr_addr       (ddr_addr),
    .ddr_burstcnt   (ddr_burstcnt),
    .ddr_busy       (ddr_busy),
    .ddr_dout       (ddr_dout),
    .ddr_dout_ready (ddr_dout_ready),
    .sync_err       (sync_err),
    .timeout_err    (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  logic [19:0] addr_q[$];
  logic [19:0] pend_q[$];

  int valid_cnt   = 0;
  int acc_cnt     = 0;
  int total_beats = 0;
  int beat_limit  = 32'h7fffffff;
  int busy_req    = -1;
  int busy_cnt    = 0;

  logic       off_clr    = 1'b0;
  logic       force_sync = 1'b0;
  logic [7:0] cache_off;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cache model: expects the next word index; optionally lies when word 5 is on the bus.
  always @(posedge clock) begin
    if (!reset_n || off_clr) cache_off <= 8'd0;
    else if (vram_valid)     cache_off <= cache_off + 8'd1;
  end
  assign ram_read_offset = (force_sync && cache_off == 8'd5) ? 8'd7 : cache_off;

  // VRAM model: busy injection and beat delivery (data = word address).
  initial begin
    logic [19:0] cur_addr;
    int          beat_n;
    bit          active;
    active = 0;
    beat_n = 0;
    ddr_busy = 1'b0;
    ddr_dout = '0;
    ddr_dout_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (ddr_rd && acc_cnt == busy_req && busy_cnt < 5) begin
        ddr_busy = 1'b1;
        busy_cnt++;
      end else begin
        ddr_busy = 1'b0;
      end
      ddr_dout_ready = 1'b0;
      if (!active && pend_q.size() > 0) begin
        cur_addr = pend_q.pop_front();
        beat_n   = 0;
        active   = 1;
      end
      if (active && total_beats < beat_limit) begin
        ddr_dout_ready = 1'b1;
        ddr_dout = 64'(cur_addr + 20'(beat_n));
        total_beats++;
        beat_n++;
        if (beat_n == 8) active = 0;
      end
    end
  end

  // Monitor: scoreboard compare of emitted words and accepted requests.
  int          rd_len    = 0;
  bit          rd_stable = 1;
  logic [19:0] rd_prev;
  always @(negedge clock) begin
    if (reset_n) begin
      if (vram_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", cache_din);
        end else begin
          check("word", cache_din, exp_q.pop_front());
        end
      end
      if (ddr_rd) begin
        if (rd_len > 0 && ddr_addr != rd_prev) rd_stable = 0;
        rd_prev = ddr_addr;
        rd_len++;
        if (!ddr_busy) begin
          if (addr_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_req: got %h expected none", ddr_addr);
          end else begin
            check("req_addr", ddr_addr, addr_q.pop_front());
          end
          check("burstcnt", ddr_burstcnt, 8);
          if (acc_cnt == busy_req) begin
            check("busy_hold_cycles", rd_len, 6);
            check("busy_hold_stable", rd_stable, 1);
            check("busy_addr", ddr_addr, 20'h01010);
          end
          pend_q.push_back(ddr_addr);
          acc_cnt++;
          rd_len    = 0;
          rd_stable = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic load_expect(input logic [19:0] base, input int n_real);
    logic [19:0] a;
    for (int i = 0; i < 256; i++) begin
      a = base + 20'(i);
      exp_q.push_back(i < n_real ? {44'd0, a} : 64'd0);
    end
    for (int b = 0; b < (n_real + 7) / 8; b++) begin
      a = base + 20'(b * 8);
      addr_q.push_back(a);
    end
  endtask

  task automatic run_fill(input logic [19:0] base, input int n_real);
    int start;
    int acc0;
    off_clr = 1'b1;
    tick();
    off_clr = 1'b0;
    load_expect(base, n_real);
    start        = valid_cnt;
    cb_base_addr = base;
    cache_wait   = 1'b1;
    for (int c = 0; c < 3000 && valid_cnt < start + 256; c++) tick();
    check("fill_words", valid_cnt - start, 256);
    check("done_no_rd", ddr_rd, 0);
    cache_wait = 1'b0;
    acc0 = acc_cnt;
    repeat (4) tick();
    check("idle_no_restart", acc_cnt - acc0, 0);
    check("all_reqs_seen", addr_q.size(), 0);
    check("all_words_seen", exp_q.size(), 0);
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    int start;
    int b0;
    int acc0;
    reset_n      = 1'b0;
    cache_wait   = 1'b0;
    cb_base_addr = '0;
    fetch_abort  = 1'b0;
    repeat (3) tick();
    check("rst_vram_valid", vram_valid, 0);
    check("rst_cache_din", cache_din, 0);
    check("rst_ddr_rd", ddr_rd, 0);
    check("rst_ddr_addr", ddr_addr, 0);
    check("rst_burstcnt", ddr_burstcnt, 8);
    check("rst_sync_err", sync_err, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_no_req", ddr_rd, 0);

    // Basic fill, then the same fill with the third request stalled for 5 cycles.
    acc0 = acc_cnt;
    run_fill(20'h01000, 256);
    check("basic_req_count", acc_cnt - acc0, 32);
    busy_req = acc_cnt + 2;
    run_fill(20'h01000, 256);
    check("busy_cycles_injected", busy_cnt, 5);

    // Address wrap at the top of VRAM.
    run_fill(20'hFFFF8, 256);

    // Back-to-back fills.
    start = valid_cnt;
    run_fill(20'h00100, 256);
    run_fill(20'h02000, 256);
    check("b2b_total_valids", valid_cnt - start, 512);

    // Abort after the third beat of the fifth burst.
    off_clr = 1'b1;
    tick();
    off_clr = 1'b0;
    load_expect(20'h03000, 256);
    start        = valid_cnt;
    b0           = total_beats;
    cb_base_addr = 20'h03000;
    cache_wait   = 1'b1;
    for (int c = 0; c < 2000 && total_beats < b0 + 35; c++) tick();
    check("abort_at_beat", total_beats - b0, 35);
    tick();
    fetch_abort = 1'b1;
    cache_wait  = 1'b0;
    tick();
    fetch_abort = 1'b0;
    repeat (12) tick();
    check("abort_valids", valid_cnt - start, 35);
    check("abort_words_left", exp_q.size(), 221);
    check("abort_reqs_left", addr_q.size(), 27);
    check("abort_beats_drained", total_beats - b0, 40);
    check("abort_idle_no_rd", ddr_rd, 0);
    exp_q.delete();
    addr_q.delete();
    run_fill(20'h05000, 256);
    check("sync_err_clean", sync_err, 0);

    // Cache reports offset 7 while word 5 is emitted.
    force_sync = 1'b1;
    run_fill(20'h06000, 256);
    force_sync = 1'b0;
    check("sync_err_set", sync_err, 1);
    run_fill(20'h00000, 256);
    check("sync_err_sticky", sync_err, 1);
`ifndef CB_FETCH_TIMEOUT_EN
    check("timeout_err_tied", timeout_err, 0);
`endif

    reset_n = 1'b0;
    #1;
    check("reset_clears_sync_err", sync_err, 0);
    check("reset_clears_valid", vram_valid, 0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

`ifdef CB_FETCH_TIMEOUT_EN
    // VRAM stops after word 100; the remaining 155 words come back as zero.
    check("timeout_err_clean", timeout_err, 0);
    beat_limit = total_beats + 101;
    run_fill(20'h04000, 101);
    check("timeout_err_set", timeout_err, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
